cache_way_select: RTL and testbench
===================================

CACHE_WAY_SELECT -- requirements
Module: cache_way_select

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the data width of each way in bits.
REQ-002 The block SHALL have parameter WAYS, default 8, meaning the number of ways; legal values are powers of two from 2 to 16.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of each performance counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a request.
REQ-008 The block SHALL have port hit, input, WAYS bits: the one-hot tag-compare hit vector.
REQ-009 The block SHALL have port way_data, input, WAYS*WIDTH bits: way i occupies bits [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: the selected way data.
REQ-013 The block SHALL have port out_way, output, $clog2(WAYS) bits: the binary index of the hit way.
REQ-014 The block SHALL have port out_hit, output, 1 bit: at least one hit bit was set.
REQ-015 The block SHALL have port out_multi, output, 1 bit: more than one hit bit was set (error).

Function
REQ-016 The block SHALL accept a request when in_valid && in_ready.
REQ-017 in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-018 Latency SHALL be exactly one cycle from acceptance to out_valid=1.
REQ-019 On acceptance, out_way SHALL register the index of the lowest set hit bit and out_data SHALL register way_data of that way.
REQ-020 When hit is all zero, out_hit SHALL be 0, out_way 0 and out_data all zero.
REQ-021 When more than one hit bit is set, out_multi SHALL be 1 and the lowest-index way SHALL still be selected.
REQ-022 While out_valid && !out_ready, all out_* SHALL hold stable and no request SHALL be accepted.
REQ-023 When out_valid && out_ready && in_valid occur together, the block SHALL load the new result in the same edge, giving full throughput.
REQ-024 When out_valid && out_ready && !in_valid, out_valid SHALL go to 0 on the next edge.
REQ-025 way_data and hit SHALL be sampled only on acceptance; changes at other times SHALL have no effect.

Reset
REQ-026 While rst=1, out_valid SHALL be 0, out_data 0, out_way 0, out_hit 0, out_multi 0 and all counters 0, independent of clk.
REQ-027 An assertion of rst while a result is held SHALL discard that result, and the block SHALL accept a request on the first edge after rst deasserts.

Configuration
REQ-028 With macro CACHE_WAY_SELECT_PERF_EN defined, the block SHALL add output ports hit_cnt, miss_cnt and multi_cnt (each CNT_W bits) and input port cnt_clr (1 bit).
REQ-029 Under CACHE_WAY_SELECT_PERF_EN, each accepted request SHALL increment hit_cnt if a hit bit was set, else miss_cnt, and multi_cnt SHALL also increment on a multi-hit.
REQ-030 Under CACHE_WAY_SELECT_PERF_EN, counters SHALL saturate at all-ones and SHALL be cleared synchronously by cnt_clr.
REQ-031 Under CACHE_WAY_SELECT_PERF_EN, when cnt_clr coincides with an increment, the clear SHALL win.
REQ-032 Without CACHE_WAY_SELECT_PERF_EN, the counter ports and logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-033 Package cache_pkg SHALL hold the default constants CACHE_WAYS=8 and CACHE_WORD_W=16, and the function clog2-based index width helper.
REQ-034 The block SHALL instantiate one sub-module, onehot_prio_enc, parametrised by WAYS, which outputs index, any and multi combinationally.

Verification
REQ-035 A bench SHALL cover: WAYS=8, WIDTH=16, way i data=16'h1000+i, hit=8'b0010_0000, out_ready=1 -> next cycle out_valid=1, out_way=5, out_data=16'h1005, out_hit=1, out_multi=0.
REQ-036 A bench SHALL cover: hit=8'h00 -> out_hit=0, out_data=16'h0000, out_way=0.
REQ-037 A bench SHALL cover: hit=8'b1000_0100 -> out_way=2, out_data=16'h1002, out_multi=1.
REQ-038 A bench SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; then out_ready=1 -> the pending request loads the next edge, giving back-to-back valid results.
REQ-039 A bench SHALL cover: rst pulsed mid-cycle while out_valid=1 -> out_valid=0 immediately; the first request after release completes in 1 cycle.
REQ-040 A bench SHALL cover, with CACHE_WAY_SELECT_PERF_EN and CNT_W=4: 20 accepted hits -> hit_cnt=4'hF (saturated); cnt_clr coinciding with a hit -> hit_cnt=0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants and helpers for the cache way-select datapath.
//   CACHE_WAYS   : default number of ways
//   CACHE_WORD_W : default data width of one way
//   idx_w()      : width of a binary way index (never less than 1 bit)
package cache_pkg;

    localparam int CACHE_WAYS   = 8;
    localparam int CACHE_WORD_W = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/onehot_prio_enc.sv
// Priority encoder for a tag-compare hit vector. Purely combinational.
// Ports:
//   hit   [WAYS-1:0]          : hit vector, nominally one-hot
//   index [idx_w(WAYS)-1:0]   : binary index of the lowest set bit (0 if none)
//   any                       : at least one bit set
//   multi                     : more than one bit set
module onehot_prio_enc
    import cache_pkg::*;
#(
    parameter int WAYS = CACHE_WAYS
) (
    input  logic [WAYS-1:0]        hit,
    output logic [idx_w(WAYS)-1:0] index,
    output logic                   any,
    output logic                   multi
);

    localparam int IDX_W = idx_w(WAYS);

    // Scan from the top down so the lowest set bit is the last writer.
    always_comb begin
        index = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                index = i[IDX_W-1:0];
            end
        end
    end

    assign any = |hit;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(hit & (hit - {{(WAYS-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/cache_way_select.sv
// Cache way select: registers the data of the hitting way behind a
// single-entry valid/ready output stage with full throughput.
// Optional feature macro: CACHE_WAY_SELECT_PERF_EN adds saturating
// hit/miss/multi-hit performance counters with a synchronous clear.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid / in_ready      : request handshake
//   hit [WAYS-1:0]           : tag-compare hit vector
//   way_data [WAYS*WIDTH-1:0]: way i at bits [i*WIDTH +: WIDTH]
//   out_valid / out_ready    : result handshake
//   out_data, out_way        : selected way data and its index
//   out_hit, out_multi       : any hit / more than one hit
//   cnt_clr, hit_cnt, miss_cnt, multi_cnt : counters (PERF_EN only)
module cache_way_select
    import cache_pkg::*;
#(
    parameter int WIDTH = CACHE_WORD_W,
    parameter int WAYS  = CACHE_WAYS,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef CACHE_WAY_SELECT_PERF_EN
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       hit_cnt,
    output logic [CNT_W-1:0]       miss_cnt,
    output logic [CNT_W-1:0]       multi_cnt,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WAYS-1:0]        hit,
    input  logic [WAYS*WIDTH-1:0]  way_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [idx_w(WAYS)-1:0] out_way,
    output logic                   out_hit,
    output logic                   out_multi
);

    localparam int IDX_W = idx_w(WAYS);

    if (WAYS < 2 || WAYS > 16 || (WAYS & (WAYS - 1)) != 0 || WIDTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("cache_way_select: illegal WAYS/WIDTH/CNT_W");
    end

    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_multi;
    logic [WIDTH-1:0] sel_data;
    logic             accept;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [IDX_W-1:0] out_way_q,   out_way_d;
    logic             out_hit_q,   out_hit_d;
    logic             out_multi_q, out_multi_d;

    onehot_prio_enc #(
        .WAYS (WAYS)
    ) u_enc (
        .hit   (hit),
        .index (enc_idx),
        .any   (enc_any),
        .multi (enc_multi)
    );

    // The output register is the only buffer, so it can take a new result
    // whenever it is empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // A miss forces zero data rather than way 0's contents.
    always_comb begin
        sel_data = '0;
        if (enc_any) begin
            sel_data = way_data[int'(enc_idx)*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_way_d   = out_way_q;
        out_hit_d   = out_hit_q;
        out_multi_d = out_multi_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_way_d   = enc_idx;
            out_hit_d   = enc_any;
            out_multi_d = enc_multi;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ---- output register stage ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_way_q   <= '0;
            out_hit_q   <= 1'b0;
            out_multi_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_way_q   <= out_way_d;
            out_hit_q   <= out_hit_d;
            out_multi_q <= out_multi_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_way   = out_way_q;
    assign out_hit   = out_hit_q;
    assign out_multi = out_multi_q;

`ifdef CACHE_WAY_SELECT_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [CNT_W-1:0] hit_cnt_q,   hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q,  miss_cnt_d;
    logic [CNT_W-1:0] multi_cnt_q, multi_cnt_d;

    // Clear has priority over any increment in the same cycle.
    always_comb begin
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        multi_cnt_d = multi_cnt_q;
        if (cnt_clr) begin
            hit_cnt_d   = '0;
            miss_cnt_d  = '0;
            multi_cnt_d = '0;
        end else if (accept) begin
            if (enc_any) begin
                hit_cnt_d = sat_inc(hit_cnt_q);
            end else begin
                miss_cnt_d = sat_inc(miss_cnt_q);
            end
            if (enc_multi) begin
                multi_cnt_d = sat_inc(multi_cnt_q);
            end
        end
    end

    // ---- counter register stage ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            multi_cnt_q <= '0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            multi_cnt_q <= multi_cnt_d;
        end
    end

    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;
    assign multi_cnt = multi_cnt_q;
`endif

endmodule

// File: tb/tb_cache_way_select.sv
// Bench for cache_way_select (WAYS=8, WIDTH=16, CNT_W=4): directed table,
// stall / reset sequences, randomized traffic against a behavioural model,
// and counter checks when CACHE_WAY_SELECT_PERF_EN is defined.
module tb_cache_way_select;

    localparam int WIDTH = 16;
    localparam int WAYS  = 8;
    localparam int CNT_W = 4;
    localparam int IW    = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [WAYS-1:0]       hit;
    logic [WAYS*WIDTH-1:0] way_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [IW-1:0]         out_way;
    logic                  out_hit;
    logic                  out_multi;
    logic                  cnt_clr;
    logic [CNT_W-1:0]      hit_cnt, miss_cnt, multi_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_way_select #(
        .WIDTH (WIDTH),
        .WAYS  (WAYS),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CACHE_WAY_SELECT_PERF_EN
        .cnt_clr   (cnt_clr),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
        .multi_cnt (multi_cnt),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hit       (hit),
        .way_data  (way_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_way   (out_way),
        .out_hit   (out_hit),
        .out_multi (out_multi)
    );

`ifndef CACHE_WAY_SELECT_PERF_EN
    assign hit_cnt   = '0;
    assign miss_cnt  = '0;
    assign multi_cnt = '0;
`endif

    typedef struct {
        logic [WAYS-1:0]  hit;
        logic [IW-1:0]    way;
        logic [WIDTH-1:0] data;
        logic             h;
        logic             m;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [WAYS*WIDTH-1:0] fixed_data();
        logic [WAYS*WIDTH-1:0] d;
        for (int i = 0; i < WAYS; i++) d[i*WIDTH +: WIDTH] = 16'h1000 + 16'(i);
        return d;
    endfunction

    // Reference selection: isolate the lowest set bit arithmetically, take
    // its log2 as the index and shift the packed data down to that way.
    task automatic ref_sel(input logic [WAYS-1:0] h_in, input logic [WAYS*WIDTH-1:0] wd,
                           output logic [IW-1:0] way, output logic [WIDTH-1:0] data,
                           output logic h, output logic m);
        logic [WAYS-1:0] lowest;
        int idx;
        lowest = h_in & (~h_in + 8'd1);
        h = (h_in != 0);
        m = ($countones(h_in) > 1);
        idx = h ? $clog2(lowest) : 0;
        way = IW'(idx);
        data = h ? WIDTH'(wd >> (idx * WIDTH)) : '0;
    endtask

    // Model state for randomized traffic.
    logic             m_valid;
    logic [IW-1:0]    m_way;
    logic [WIDTH-1:0] m_data;
    logic             m_h, m_m;
    int               m_hc, m_mc, m_xc;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'b0010_0000, 3'd5, 16'h1005, 1'b1, 1'b0};
        tbl[1] = '{8'b0000_0000, 3'd0, 16'h0000, 1'b0, 1'b0};
        tbl[2] = '{8'b1000_0100, 3'd2, 16'h1002, 1'b1, 1'b1};
        tbl[3] = '{8'b0000_0001, 3'd0, 16'h1000, 1'b1, 1'b0};
        tbl[4] = '{8'b1000_0000, 3'd7, 16'h1007, 1'b1, 1'b0};
        tbl[5] = '{8'b1111_1111, 3'd0, 16'h1000, 1'b1, 1'b1};
        tbl[6] = '{8'b0110_0000, 3'd5, 16'h1005, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; hit = '0; cnt_clr = 1'b0;
        way_data = fixed_data();

        // Reset state, held while clock runs.
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_way",   64'(out_way),   64'd0);
        chk("rst_out_hit",   64'(out_hit),   64'd0);
        chk("rst_out_multi", 64'(out_multi), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
`ifdef CACHE_WAY_SELECT_PERF_EN
        chk("rst_hit_cnt",   64'(hit_cnt),   64'd0);
        chk("rst_miss_cnt",  64'(miss_cnt),  64'd0);
        chk("rst_multi_cnt", 64'(multi_cnt), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Table: back-to-back requests with out_ready held high.
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            hit = tbl[k].hit;
            #1 chk($sformatf("tbl%0d_in_ready", k), 64'(in_ready), 64'd1);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("tbl%0d_way",   k), 64'(out_way),   64'(tbl[k].way));
            chk($sformatf("tbl%0d_data",  k), 64'(out_data),  64'(tbl[k].data));
            chk($sformatf("tbl%0d_hit",   k), 64'(out_hit),   64'(tbl[k].h));
            chk($sformatf("tbl%0d_multi", k), 64'(out_multi), 64'(tbl[k].m));
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Stall: held result stays put, pending request waits, way_data noise ignored.
        in_valid = 1'b1; hit = 8'b0010_0000; out_ready = 1'b1;
        @(negedge clk);
        chk("stall_load_way", 64'(out_way), 64'd5);
        out_ready = 1'b0; hit = 8'b0000_1000;
        for (int c = 0; c < 3; c++) begin
            way_data = {$urandom, $urandom, $urandom, $urandom};
            #1 chk($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
            @(negedge clk);
            chk($sformatf("stall%0d_valid", c), 64'(out_valid), 64'd1);
            chk($sformatf("stall%0d_way",   c), 64'(out_way),   64'd5);
            chk($sformatf("stall%0d_data",  c), 64'(out_data),  64'h1005);
        end
        way_data = fixed_data();
        out_ready = 1'b1;
        #1 chk("release_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("release_valid", 64'(out_valid), 64'd1);
        chk("release_way",   64'(out_way),   64'd3);
        chk("release_data",  64'(out_data),  64'h1003);
        in_valid = 1'b0;
        @(negedge clk);
        chk("release_drain", 64'(out_valid), 64'd0);

        // Asynchronous reset while a result is held.
        in_valid = 1'b1; hit = 8'b0100_0000; out_ready = 1'b0;
        @(negedge clk);
        chk("hold_way", 64'(out_way), 64'd6);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data",  64'(out_data),  64'd0);
        chk("async_rst_way",   64'(out_way),   64'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; hit = 8'b0000_0010; out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_way",   64'(out_way),   64'd1);
        chk("post_rst_data",  64'(out_data),  64'h1001);
        in_valid = 1'b0;

        // Randomized traffic from a clean reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0; m_way = '0; m_data = '0; m_h = 1'b0; m_m = 1'b0;
        m_hc = 0; m_mc = 0; m_xc = 0;
        for (int n = 0; n < 300; n++) begin
            logic acc;
            logic [IW-1:0] rw; logic [WIDTH-1:0] rd; logic rh, rm;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: hit = '0;
                1: hit = 8'd1 << $urandom_range(0, WAYS - 1);
                default: hit = 8'($urandom);
            endcase
            way_data = {$urandom, $urandom, $urandom, $urandom};
            cnt_clr  = ($urandom_range(0, 15) == 0);
            #1 chk("rnd_in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
            acc = in_valid && (!m_valid || out_ready);
            ref_sel(hit, way_data, rw, rd, rh, rm);
            if (cnt_clr) begin
                m_hc = 0; m_mc = 0; m_xc = 0;
            end else if (acc) begin
                if (rh) m_hc = (m_hc < 15) ? m_hc + 1 : 15;
                else    m_mc = (m_mc < 15) ? m_mc + 1 : 15;
                if (rm) m_xc = (m_xc < 15) ? m_xc + 1 : 15;
            end
            if (acc) begin
                m_valid = 1'b1; m_way = rw; m_data = rd; m_h = rh; m_m = rm;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            @(negedge clk);
            chk("rnd_valid", 64'(out_valid), 64'(m_valid));
            chk("rnd_way",   64'(out_way),   64'(m_way));
            chk("rnd_data",  64'(out_data),  64'(m_data));
            chk("rnd_hit",   64'(out_hit),   64'(m_h));
            chk("rnd_multi", 64'(out_multi), 64'(m_m));
`ifdef CACHE_WAY_SELECT_PERF_EN
            chk("rnd_hit_cnt",   64'(hit_cnt),   64'(m_hc));
            chk("rnd_miss_cnt",  64'(miss_cnt),  64'(m_mc));
            chk("rnd_multi_cnt", 64'(multi_cnt), 64'(m_xc));
`endif
        end
        cnt_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        way_data = fixed_data();
        @(negedge clk);

`ifdef CACHE_WAY_SELECT_PERF_EN
        // Saturation and clear priority.
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr_hit_cnt",  64'(hit_cnt),  64'd0);
        chk("clr_miss_cnt", 64'(miss_cnt), 64'd0);
        in_valid = 1'b1; hit = 8'b0000_0001;
        repeat (20) @(negedge clk);
        in_valid = 1'b0;
        chk("sat_hit_cnt",   64'(hit_cnt),   64'hF);
        chk("sat_miss_cnt",  64'(miss_cnt),  64'd0);
        chk("sat_multi_cnt", 64'(multi_cnt), 64'd0);
        in_valid = 1'b1; cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr_wins_hit_cnt", 64'(hit_cnt), 64'd0);
        hit = 8'b0000_0000;
        @(negedge clk);
        chk("miss_inc", 64'(miss_cnt), 64'd1);
        hit = 8'b0000_0011;
        @(negedge clk);
        in_valid = 1'b0;
        chk("multi_hit_cnt",   64'(hit_cnt),   64'd1);
        chk("multi_multi_cnt", 64'(multi_cnt), 64'd1);
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
